// File: rtl/karatsuba_seq_ctrl_if.sv
// Operand/result handshake and shared 16x16 multiplier bus of the Karatsuba sequencer.
// The slave side is the sequencer; the master side is the requester plus the multiplier.
interface karatsuba_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] P;
    logic        busy;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_p;

    modport slave (
        input  in_valid, A, B, out_ready, mul_p,
        output in_ready, out_valid, P, busy, mul_a, mul_b
    );

    modport master (
        output in_valid, A, B, out_ready, mul_p,
        input  in_ready, out_valid, P, busy, mul_a, mul_b
    );
endinterface

// File: rtl/karatsuba_seq_ctrl.sv
// 32x32 unsigned multiply built from three passes through one shared 16x16 multiplier
// (Z0 = lo*lo, Z2 = hi*hi, Z1 = (lo+hi)*(lo+hi)) followed by Karatsuba recombination.
module karatsuba_seq_ctrl #(
    parameter int MUL_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    karatsuba_seq_ctrl_if.slave  bus
);
    localparam int CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PH_Z0   = 3'd1,
        PH_Z2   = 3'd2,
        PH_Z1   = 3'd3,
        COMBINE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [31:0]      a_r, b_r, z0_r, z2_r;
    logic [33:0]      z1_r;
    logic [63:0]      p_r;
    logic             out_valid_r, in_ready_r, busy_r;
    logic [15:0]      mul_a_r, mul_b_r;

    logic             accept_s, phase_end_s;
    logic [31:0]      a_nxt_s, b_nxt_s;
    logic [16:0]      sa_s, sb_s;
    logic [33:0]      z1_s, mid_s;
    logic [63:0]      p_s;
    logic [15:0]      mul_a_s, mul_b_s;

    // in_ready is registered, so an accept is only possible once it has been presented.
    assign accept_s    = (state_r == IDLE) && in_ready_r && bus.in_valid;
    assign phase_end_s = (cnt_r == CNT_LAST);

    assign sa_s = {1'b0, a_r[15:0]} + {1'b0, a_r[31:16]};
    assign sb_s = {1'b0, b_r[15:0]} + {1'b0, b_r[31:16]};

    // The multiplier only sees the low 16 bits of each sum; the carries are folded back here.
    assign z1_s = {2'b00, bus.mul_p}
                + (sa_s[16] ? {2'b00, sb_s[15:0], 16'h0000} : 34'h0_0000_0000)
                + (sb_s[16] ? {2'b00, sa_s[15:0], 16'h0000} : 34'h0_0000_0000)
                + ((sa_s[16] && sb_s[16]) ? 34'h1_0000_0000 : 34'h0_0000_0000);

    assign mid_s = z1_r - {2'b00, z2_r} - {2'b00, z0_r};
    assign p_s   = {z2_r, 32'h0000_0000}
                 + ({30'h0000_0000, mid_s} << 16)
                 + {32'h0000_0000, z0_r};

    // Next-state and phase-counter logic.
    always_comb begin
        next_state_s = state_r;
        cnt_nxt_s    = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = PH_Z0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            PH_Z0, PH_Z2, PH_Z1: begin
                if (phase_end_s) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    case (state_r)
                        PH_Z0:   next_state_s = PH_Z2;
                        PH_Z2:   next_state_s = PH_Z1;
                        default: next_state_s = COMBINE;
                    endcase
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            COMBINE: next_state_s = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_nxt_s    = {CNT_W{1'b0}};
            end
        endcase
    end

    // Multiplier operands for the upcoming state, so they are registered in time for its first cycle.
    always_comb begin
        a_nxt_s = accept_s ? bus.A : a_r;
        b_nxt_s = accept_s ? bus.B : b_r;
        mul_a_s = 16'h0000;
        mul_b_s = 16'h0000;
        case (next_state_s)
            PH_Z0: begin
                mul_a_s = a_nxt_s[15:0];
                mul_b_s = b_nxt_s[15:0];
            end
            PH_Z2: begin
                mul_a_s = a_nxt_s[31:16];
                mul_b_s = b_nxt_s[31:16];
            end
            PH_Z1: begin
                mul_a_s = sa_s[15:0];
                mul_b_s = sb_s[15:0];
            end
            default: begin
                mul_a_s = 16'h0000;
                mul_b_s = 16'h0000;
            end
        endcase
    end

    // State, operand, partial-product and registered-output updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            a_r         <= 32'h0000_0000;
            b_r         <= 32'h0000_0000;
            z0_r        <= 32'h0000_0000;
            z2_r        <= 32'h0000_0000;
            z1_r        <= 34'h0_0000_0000;
            p_r         <= 64'h0000_0000_0000_0000;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            mul_a_r     <= 16'h0000;
            mul_b_r     <= 16'h0000;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                a_r <= bus.A;
                b_r <= bus.B;
            end
            if ((state_r == PH_Z0) && phase_end_s) begin
                z0_r <= bus.mul_p;
            end
            if ((state_r == PH_Z2) && phase_end_s) begin
                z2_r <= bus.mul_p;
            end
            if ((state_r == PH_Z1) && phase_end_s) begin
                z1_r <= z1_s;
            end
            if (state_r == COMBINE) begin
                p_r <= p_s;
            end
            out_valid_r <= (next_state_s == DONE);
            in_ready_r  <= (next_state_s == IDLE);
            busy_r      <= (next_state_s != IDLE);
            mul_a_r     <= mul_a_s;
            mul_b_r     <= mul_b_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.P         = p_r;
    assign bus.busy      = busy_r;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;
endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Bench for karatsuba_seq_ctrl: one instance with a combinational multiplier (MUL_LAT=0)
// and one with a 2-stage pipelined multiplier (MUL_LAT=2), checked against a*b.
module tb_karatsuba_seq_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] pipe1, pipe2;

    karatsuba_seq_ctrl_if if0 ();
    karatsuba_seq_ctrl_if if1 ();

    karatsuba_seq_ctrl #(.MUL_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    karatsuba_seq_ctrl #(.MUL_LAT(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    assign if0.mul_p = {16'h0000, if0.mul_a} * {16'h0000, if0.mul_b};

    // Two-stage shared multiplier model for the MUL_LAT=2 instance.
    always_ff @(posedge clk) begin
        pipe1 <= {16'h0000, if1.mul_a} * {16'h0000, if1.mul_b};
        pipe2 <= pipe1;
    end
    assign if1.mul_p = pipe2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ov(input int d);
        return (d == 0) ? if0.out_valid : if1.out_valid;
    endfunction
    function automatic logic rdy(input int d);
        return (d == 0) ? if0.in_ready : if1.in_ready;
    endfunction
    function automatic logic bsy(input int d);
        return (d == 0) ? if0.busy : if1.busy;
    endfunction
    function automatic logic [63:0] p_of(input int d);
        return (d == 0) ? if0.P : if1.P;
    endfunction
    function automatic logic [15:0] ma(input int d);
        return (d == 0) ? if0.mul_a : if1.mul_a;
    endfunction
    function automatic logic [15:0] mb(input int d);
        return (d == 0) ? if0.mul_b : if1.mul_b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input int d, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (d == 0) begin
            if0.in_valid = v; if0.A = a; if0.B = b;
        end else begin
            if1.in_valid = v; if1.A = a; if1.B = b;
        end
    endtask

    task automatic drive_or(input int d, input logic v);
        if (d == 0) if0.out_ready = v;
        else        if1.out_ready = v;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for in_ready, then presents one operand pair for exactly one accept edge.
    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        while (rdy(d) !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("issue_ready", {63'd0, rdy(d)}, 64'd1);
        drive_in(d, 1'b1, a, b);
        tick();
        drive_in(d, 1'b0, a, b);
    endtask

    // Called just after the accept edge: counts edges to out_valid, optionally checking operands per phase.
    task automatic await_result(input int d, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] exp_p, input int lat, input bit chk_mul);
        int edges;
        int ph;
        logic [15:0] ea, eb;
        edges = 0;
        while (ov(d) !== 1'b1 && edges < 40) begin
            if (chk_mul) begin
                ph = edges / (lat + 1);
                case (ph)
                    0:       begin ea = a[15:0];  eb = b[15:0];  end
                    1:       begin ea = a[31:16]; eb = b[31:16]; end
                    2:       begin ea = 16'(a[15:0] + a[31:16]); eb = 16'(b[15:0] + b[31:16]); end
                    default: begin ea = 16'h0000; eb = 16'h0000; end
                endcase
                check("mul_a", {48'd0, ma(d)}, {48'd0, ea});
                check("mul_b", {48'd0, mb(d)}, {48'd0, eb});
            end
            tick();
            edges++;
        end
        check("latency", 64'(edges), 64'(3 * (lat + 1) + 1));
        check("product", p_of(d), exp_p);
    endtask

    task automatic retire(input int d);
        drive_or(d, 1'b1);
        tick();
        drive_or(d, 1'b0);
        check("ov_drop", {63'd0, ov(d)}, 64'd0);
        check("ready_after", {63'd0, rdy(d)}, 64'd1);
    endtask

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_p, input int lat, input bit chk_mul);
        issue(d, a, b);
        await_result(d, a, b, exp_p, lat, chk_mul);
        retire(d);
    endtask

    // in_valid and out_ready held high: in_ready must recur with the fixed period.
    task automatic throughput(input int d, input int lat);
        int marks[3];
        int n;
        marks = '{0, 0, 0};
        n = 0;
        drive_or(d, 1'b1);
        for (int c = 0; c < 80; c++) begin
            if (rdy(d) === 1'b1) begin
                marks[n] = c;
                n++;
            end
            if (n == 3) break;
            drive_in(d, 1'b1, $urandom, $urandom);
            tick();
        end
        drive_in(d, 1'b0, 32'h0, 32'h0);
        tick();
        drive_or(d, 1'b0);
        check("thru_count", 64'(n), 64'd3);
        check("thru_gap1", 64'(marks[1] - marks[0]), 64'(3 * (lat + 1) + 3));
        check("thru_gap2", 64'(marks[2] - marks[1]), 64'(3 * (lat + 1) + 3));
    endtask

    initial begin
        logic [31:0] a, b;
        logic [63:0] e;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        drive_in(0, 1'b0, 32'h0, 32'h0);
        drive_in(1, 1'b0, 32'h0, 32'h0);
        drive_or(0, 1'b0);
        drive_or(1, 1'b0);
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", {63'd0, rdy(d)}, 64'd0);
            check("rst_out_valid", {63'd0, ov(d)}, 64'd0);
            check("rst_p", p_of(d), 64'd0);
            check("rst_mul_a", {48'd0, ma(d)}, 64'd0);
            check("rst_busy", {63'd0, bsy(d)}, 64'd0);
        end
        rst = 1'b0;
        tick();
        check("post_rst_ready0", {63'd0, rdy(0)}, 64'd1);
        check("post_rst_ready1", {63'd0, rdy(1)}, 64'd1);

        // Directed products, operand sequence checked on both latencies.
        run_op(0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 0, 1'b1);
        run_op(1, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 2, 1'b1);
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1'b1);
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2, 1'b1);
        run_op(0, 32'h8000_8000, 32'h8000_8000, 64'h4000_8000_4000_0000, 0, 1'b1);
        run_op(1, 32'h8000_8000, 32'h8000_8000, 64'h4000_8000_4000_0000, 2, 1'b0);

        // Backpressure: result held while out_ready is low; in_valid pulses ignored.
        issue(0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        e = {32'h0, 32'hDEAD_BEEF} * {32'h0, 32'h0BAD_F00D};
        await_result(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, e, 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", {63'd0, ov(0)}, 64'd1);
            check("bp_p", p_of(0), e);
            check("bp_in_ready", {63'd0, rdy(0)}, 64'd0);
            drive_in(0, (k % 2 == 0), $urandom, $urandom);
            tick();
        end
        drive_in(0, 1'b0, 32'h0, 32'h0);
        check("bp_p_end", p_of(0), e);
        retire(0);
        check("bp_busy", {63'd0, bsy(0)}, 64'd0);

        // in_valid together with out_ready in DONE: only the output handshake happens.
        issue(0, 32'h0001_0001, 32'hFFFF_0002);
        await_result(0, 32'h0001_0001, 32'hFFFF_0002,
                     {32'h0, 32'h0001_0001} * {32'h0, 32'hFFFF_0002}, 0, 1'b0);
        drive_in(0, 1'b1, 32'h1357_9BDF, 32'h2468_ACE0);
        drive_or(0, 1'b1);
        tick();
        drive_or(0, 1'b0);
        check("sim_ov_drop", {63'd0, ov(0)}, 64'd0);
        check("sim_busy", {63'd0, bsy(0)}, 64'd0);
        check("sim_ready", {63'd0, rdy(0)}, 64'd1);
        tick();
        drive_in(0, 1'b0, 32'h0, 32'h0);
        check("sim_accept", {63'd0, bsy(0)}, 64'd1);
        await_result(0, 32'h1357_9BDF, 32'h2468_ACE0,
                     {32'h0, 32'h1357_9BDF} * {32'h0, 32'h2468_ACE0}, 0, 1'b0);
        retire(0);

        // Reset during PH_Z2 abandons the operation.
        issue(0, 32'hAAAA_5555, 32'h5555_AAAA);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ov", {63'd0, ov(0)}, 64'd0);
        check("mid_rst_busy", {63'd0, bsy(0)}, 64'd0);
        check("mid_rst_mul_a", {48'd0, ma(0)}, 64'd0);
        check("mid_rst_ready0", {63'd0, rdy(0)}, 64'd0);
        tick();
        check("mid_rst_ready1", {63'd0, rdy(0)}, 64'd1);
        for (int k = 0; k < 6; k++) tick();
        check("mid_rst_no_ov", {63'd0, ov(0)}, 64'd0);
        run_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 0, 1'b1);

        throughput(0, 0);
        throughput(1, 2);

        // Randomized vectors against the plain 64-bit product, carries biased in.
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) a[31:16] = 16'hFFFF;
            if (i % 4 == 2) b[15:0]  = 16'hFFFF;
            run_op(0, a, b, {32'h0, a} * {32'h0, b}, 0, 1'b0);
        end
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) a[15:0]  = 16'hFFFF;
            if (i % 4 == 2) b[31:16] = 16'hFFFF;
            run_op(1, a, b, {32'h0, a} * {32'h0, b}, 2, (i % 50 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
